ldpc_3gpp_enc_src_ctrl: RTL
===========================

Name: ldpc_3gpp_enc_src_ctrl

Overview:
- Input sequencer that sits directly upstream of the encoder A*u'/C*u' accumulation stage.
- Accepts a flat stream of systematic data words for one code block.
- Slices the stream into Zc-sized columns of the base graph and drives the accumulation stage's upload interface: write, start, strobe, column index and data.
- Applies frame-level backpressure until the downstream encoder releases the buffers.

Parameters:
- pADDR_W, 8, word-counter width; ceil(Zc/pDAT_W) must be <= 2^pADDR_W.
- pDAT_W, 8, data word width in bits.
- pIDX_GR, 0, base graph index: 0 = BG1 (22 systematic columns max), 1 = BG2 (10 max).

Ports:
- iclk, in, 1, clock.
- ireset_n, in, 1, asynchronous active-low reset.
- iclkena, in, 1, clock enable; all state holds when low.
- iused_zc, in, hb_zc_t (9), lifting size Zc; sampled on the accepted sop word.
- inum_col, in, 5, systematic columns used (Kb); sampled on the accepted sop word; 1..cGR_SYST_BIT_COL[pIDX_GR].
- ival, in, 1, input word valid.
- isop, in, 1, first word of frame.
- idat, in, pDAT_W, input data.
- ordy, out, 1, ready; a word is accepted when ival & ordy & iclkena.
- irelease, in, 1, downstream finished the frame; unblocks input.
- owrite, out, 1, upload write strobe.
- owstart, out, 1, first word of frame (same cycle as owrite).
- owstrb, out, strb_t, {sof, eof, sop, eop}.
- owcol, out, hb_col_t (5), current column index.
- owdat, out, pDAT_W, data.
- odone, out, 1, one-cycle pulse: frame fully uploaded.
- oerr, out, 1, sticky error flag; cleared by the next accepted sop.

Behaviour:
- Reset values: ordy=0 while reset is asserted and 1 on the first enabled cycle after release; every other output is 0. State goes to IDLE.
- Frame geometry:
  - nwords = ceil(Zc/pDAT_W), computed combinationally from iused_zc.
  - nwords and inum_col are registered on the accepted sop word.
  - The word counter runs 0..nwords-1. The column counter runs 0..inum_col-1.
- Output latency: exactly 1 cycle from acceptance to owrite. All outputs are registered.
- IDLE (ordy=1):
  - ival & isop: emit word 0 with owstart=1, sof=1, sop=1, owcol=0; go to LOAD.
  - ival & !isop: drop the word and set oerr.
- LOAD (ordy=1). For each accepted word:
  - sop = (word counter == 0).
  - eop = (word counter == nwords-1).
  - On eop the word counter wraps to 0 and the column counter increments.
  - On the last word of the last column: eof=1, go to WAIT_REL.
- Degenerate frame: with nwords=1 and inum_col=1, the single word carries sof, eof, sop and eop together. odone follows and the block goes to WAIT_REL directly from IDLE.
- isop during LOAD:
  - Abort the current frame and set oerr.
  - Restart with this word as word 0 of a new frame: sof=1, owstart=1, geometry re-sampled.
  - No odone is issued for the aborted frame.
- WAIT_REL (ordy=0): input is stalled.
  - odone pulses on the cycle after the eof write.
  - irelease moves the block to IDLE on the next cycle.
  - irelease in any other state is ignored.
- Gaps: ival=0 in LOAD holds the counters; owrite=0 on the next cycle.
- iclkena=0: registers and the odone pulse are frozen; owrite is not repeated.
- Reset mid-frame: all counters clear and the partial frame is discarded.

Optional Feature:
- LDPC_3GPP_ENC_SRC_PAD_EN defined: when Zc mod pDAT_W != 0, the bits at and above (Zc mod pDAT_W) of each column's last word (eop) are forced to 0 on owdat.
- Undefined: idat is passed through unmodified and upstream guarantees zero padding.

Decomposition:
- Shared package ldpc_3gpp_enc_types: strb_t, hb_zc_t, hb_col_t, dat_t, and cGR_SYST_BIT_COL from the 3gpp constants.
- Local state enum: IDLE, LOAD, WAIT_REL.
- One natural sub-module: ldpc_3gpp_enc_src_cnt, a word/column counter pair with terminal-count flags.

Test Plan:
- Zc=16, pDAT_W=8, Kb=22, 44 back-to-back words: owrite on 44 cycles; owcol increments every 2 words; sof on write 1, eof on write 44; odone 1 cycle after write 44; ordy=0 until irelease.
- Zc=20, pDAT_W=8, PAD_EN defined, idat=8'hFF: 3 words per column; every eop word is 8'h0F, all others 8'hFF.
- Kb=10 frame (pIDX_GR=1) with ival deasserted every other cycle: exactly 10*nwords writes with no duplicates and correct owcol at each write.
- isop asserted at word 7 of a frame: oerr=1; next write has owstart=1, owcol=0; no odone until the new frame completes.
- Stray ival without isop in IDLE: no owrite, oerr=1; the next valid sop clears oerr.
- ireset_n asserted mid-LOAD then released: all outputs are 0 and ordy returns to 1 on the first enabled cycle after release. A fresh frame then uploads correctly.

Source files
------------

// File: rtl/ldpc_3gpp_enc_src_ctrl_pkg.sv
// ldpc_3gpp_enc_types: shared encoder types, base-graph limits and geometry helper.
package ldpc_3gpp_enc_types;

    typedef struct packed {
        logic sof;
        logic eof;
        logic sop;
        logic eop;
    } strb_t;

    typedef logic [8:0] hb_zc_t;
    typedef logic [4:0] hb_col_t;

    localparam int cDAT_W = 8;
    typedef logic [cDAT_W-1:0] dat_t;

    // systematic column count per base graph: BG1, BG2
    localparam int cGR_SYST_BIT_COL [2] = '{22, 10};

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_src_ctrl_if.sv
// ldpc_3gpp_enc_src_ctrl_if: upload bus into the A*u'/C*u' accumulation stage.
interface ldpc_3gpp_enc_src_ctrl_if import ldpc_3gpp_enc_types::*; #(
    parameter int pDAT_W = 8
);

    logic              owrite;
    logic              owstart;
    strb_t             owstrb;
    hb_col_t           owcol;
    logic [pDAT_W-1:0] owdat;

    modport master (output owrite, owstart, owstrb, owcol, owdat);
    modport slave  (input  owrite, owstart, owstrb, owcol, owdat);

endinterface

// File: rtl/ldpc_3gpp_enc_src_cnt.sv
// ldpc_3gpp_enc_src_cnt: word/column position counters with frame geometry and terminal flags.
module ldpc_3gpp_enc_src_cnt import ldpc_3gpp_enc_types::*; #(
    parameter int pADDR_W = 8
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic               ild,
    input  logic               iinc,
    input  logic [pADDR_W-1:0] iword_max,
    input  hb_col_t            icol_max,
    output hb_col_t            ocol,
    output logic               osop,
    output logic               oeop,
    output logic               olast
);

    logic [pADDR_W-1:0] word_q, word_max_q, word_max, word;
    hb_col_t            col_q, col_max_q, col_max;

    // a load presents position 0 with the fresh geometry in the same cycle
    always_comb begin
        word_max = ild ? iword_max : word_max_q;
        col_max  = ild ? icol_max : col_max_q;
        word     = ild ? '0 : word_q;
        ocol     = ild ? '0 : col_q;
        osop     = word == '0;
        oeop     = word == word_max;
        olast    = oeop && ocol == col_max;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            word_q     <= '0;
            col_q      <= '0;
            word_max_q <= '0;
            col_max_q  <= '0;
        end else if (iclkena) begin
            if (ild) begin
                word_max_q <= iword_max;
                col_max_q  <= icol_max;
            end
            if (iinc) begin
                word_q <= oeop ? '0 : word + 1'b1;
                col_q  <= oeop ? ocol + 1'b1 : ocol;
            end
        end
    end

endmodule

// File: rtl/ldpc_3gpp_enc_src_ctrl.sv
// ldpc_3gpp_enc_src_ctrl: slices a systematic word stream into Zc columns for the upload bus.
// Optional LDPC_3GPP_ENC_SRC_PAD_EN zeroes the bits beyond Zc in each column's last word.
module ldpc_3gpp_enc_src_ctrl import ldpc_3gpp_enc_types::*; #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8,
    parameter int pIDX_GR = 0
) (
    input  logic                          iclk,
    input  logic                          ireset_n,
    input  logic                          iclkena,
    input  hb_zc_t                        iused_zc,
    input  logic [4:0]                    inum_col,
    input  logic                          ival,
    input  logic                          isop,
    input  logic [pDAT_W-1:0]             idat,
    output logic                          ordy,
    input  logic                          irelease,
    ldpc_3gpp_enc_src_ctrl_if.master      wr,
    output logic                          odone,
    output logic                          oerr
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_REL} state_t;

    localparam int cKB_MAX = cGR_SYST_BIT_COL[pIDX_GR];

    state_t             state, state_nxt;
    logic               acc, start, emit, stray, sop, eop, last, done_pend;
    logic [pADDR_W-1:0] word_max;
    hb_col_t            col_max, col;
    logic [pDAT_W-1:0]  dat;

    assign word_max = pADDR_W'(ceil_div(32'(iused_zc), pDAT_W) - 1);
    // out-of-range column counts are clamped to the base graph's systematic width
    assign col_max  = (inum_col == '0) ? '0 :
                      (32'(inum_col) > cKB_MAX) ? hb_col_t'(cKB_MAX - 1) : inum_col - 1'b1;

    ldpc_3gpp_enc_src_cnt #(.pADDR_W(pADDR_W)) u_cnt (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .ild       (start),
        .iinc      (emit),
        .iword_max (word_max),
        .icol_max  (col_max),
        .ocol      (col),
        .osop      (sop),
        .oeop      (eop),
        .olast     (last)
    );

`ifdef LDPC_3GPP_ENC_SRC_PAD_EN
    hb_zc_t            zc_q, zc;
    int unsigned       rem;
    logic [pDAT_W-1:0] pad_mask;
    always_comb begin
        zc       = start ? iused_zc : zc_q;
        rem      = 32'(zc) % pDAT_W;
        pad_mask = (eop && rem != 0) ? ~({pDAT_W{1'b1}} << rem) : '1;
        dat      = idat & pad_mask;
    end
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)
            zc_q <= '0;
        else if (iclkena && start)
            zc_q <= iused_zc;
    end
`else
    assign dat = idat;
`endif

    // a sop is always taken as word 0, even mid-frame (abort and restart)
    always_comb begin
        acc       = ival && ordy && iclkena;
        start     = acc && isop;
        emit      = acc && (isop || state == LOAD);
        stray     = acc && !isop && state == IDLE;
        state_nxt = state;
        if (emit)
            state_nxt = last ? WAIT_REL : LOAD;
        else if (state == WAIT_REL && irelease)
            state_nxt = IDLE;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state      <= IDLE;
            ordy       <= 1'b0;
            wr.owrite  <= 1'b0;
            wr.owstart <= 1'b0;
            wr.owstrb  <= '0;
            wr.owcol   <= '0;
            wr.owdat   <= '0;
            done_pend  <= 1'b0;
            odone      <= 1'b0;
            oerr       <= 1'b0;
        end else begin
            // owrite follows emit every clock so a stalled enable never repeats a write
            wr.owrite <= emit;
            if (iclkena) begin
                state      <= state_nxt;
                ordy       <= state_nxt != WAIT_REL;
                wr.owstart <= start;
                wr.owstrb  <= emit ? strb_t'({start, last, sop, eop}) : '0;
                done_pend  <= emit && last;
                odone      <= done_pend;
                oerr       <= start ? (state == LOAD) : (oerr || stray);
                if (emit) begin
                    wr.owcol <= col;
                    wr.owdat <= dat;
                end
            end
        end
    end

endmodule
